// File: rtl/bcd_pkg.sv
// Shared BCD constants, state encoding and the nibble clamp helper.
package bcd_pkg;

  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [NIBBLE_W-1:0] BCD_ZERO = 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Non-decimal nibbles (A..F) saturate to 9 so the count stays valid BCD.
  function automatic logic [NIBBLE_W-1:0] clamp_nibble(input logic [NIBBLE_W-1:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

endpackage

// File: rtl/bcd_countdown_if.sv
// Control and status bundle for the BCD down-counter.
// Handshake: there is no valid/ready pair and no backpressure. load is a
// single-cycle strobe sampled on the rising clock edge and always wins over
// enable; enable is a tick qualifier, one decrement per high cycle. All
// status signals are registered and valid one cycle after the causing edge.
interface bcd_countdown_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  enable;
  logic [4*DIGITS-1:0]   digits;
  logic [DIGITS-1:0]     borrow;
  logic                  done;
  logic                  running;
  logic                  zero;
  logic [1:0]            state;    // debug view of the FSM state

  modport master (
    output load, load_value, enable,
    input  digits, borrow, done, running, zero, state
  );

  modport slave (
    input  load, load_value, enable,
    output digits, borrow, done, running, zero, state
  );
endinterface

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the down-counter: loads, decrements and wraps 0 -> 9.
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                load_i,
  input  logic [NIBBLE_W-1:0] load_value_i,
  input  logic                dec_i,
  output logic [NIBBLE_W-1:0] digit_o,
  output logic                borrow_o
);

  logic [NIBBLE_W-1:0] digit_q, digit_d;

  // Next digit: load beats decrement; a zero digit wraps to nine.
  always_comb begin
    digit_d = digit_q;
    if (load_i)
      digit_d = load_value_i;
    else if (dec_i)
      digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : digit_q - 4'd1;
  end

  // Digit register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) digit_q <= BCD_ZERO;
    else        digit_q <= digit_d;
  end

  assign digit_o  = digit_q;
  assign borrow_o = (digit_q == BCD_ZERO) && dec_i;

endmodule

// File: rtl/bcd_countdown.sv
// Multi-digit BCD down-counter with parallel load, optional auto-reload and
// a one-cycle done pulse when the count reaches zero.
module bcd_countdown
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic             clock,
  input logic             reset,
  bcd_countdown_if.slave  bus
);

  localparam int W = NIBBLE_W * DIGITS;
  localparam logic [W-1:0] COUNT_ONE = {{(W-1){1'b0}}, 1'b1};

  state_e              state_q;
  logic [W-1:0]        reload_q;
  logic [DIGITS-1:0]   borrow_q;
  logic                done_q, running_q, zero_q;

  logic [W-1:0]        clamped_d, cell_value_d, digits_w;
  logic [DIGITS-1:0]   borrow_w, dec_w;
  logic                is_zero, is_one, dec_en, reload_evt, cell_load;

  // Clamp each incoming nibble to a legal decimal digit.
  always_comb begin
    clamped_d = '0;
    for (int i = 0; i < DIGITS; i++)
      clamped_d[NIBBLE_W*i +: NIBBLE_W] = clamp_nibble(bus.load_value[NIBBLE_W*i +: NIBBLE_W]);
  end

  assign is_zero    = (digits_w == '0);
  assign is_one     = (digits_w == COUNT_ONE);
  // After an auto-reload expiry the counter sits at zero in RUN; the next
  // tick restores the reload value instead of decrementing.
  assign reload_evt = AUTO_RELOAD && (state_q == RUN) && bus.enable && !bus.load && is_zero;
  assign dec_en     = (state_q == RUN) && bus.enable && !bus.load && !is_zero;
  assign cell_load  = bus.load || reload_evt;
  assign cell_value_d = bus.load ? clamped_d : reload_q;

  // Digit k decrements only when every lower digit was zero, which is exactly
  // the borrow out of digit k-1.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_first
      assign dec_w[k] = dec_en;
    end else begin : g_rest
      assign dec_w[k] = borrow_w[k-1];
    end
    bcd_digit_dec u_digit (
      .clock        (clock),
      .reset        (reset),
      .load_i       (cell_load),
      .load_value_i (cell_value_d[NIBBLE_W*k +: NIBBLE_W]),
      .dec_i        (dec_w[k]),
      .digit_o      (digits_w[NIBBLE_W*k +: NIBBLE_W]),
      .borrow_o     (borrow_w[k])
    );
  end

  // Control FSM with registered status outputs and the reload register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      reload_q  <= '0;
      borrow_q  <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      borrow_q <= '0;
      done_q   <= 1'b0;
      if (bus.load) begin
        reload_q <= clamped_d;
        if (clamped_d != '0) begin
          state_q   <= RUN;
          running_q <= 1'b1;
          zero_q    <= 1'b0;
        end else begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          zero_q    <= 1'b1;
        end
      end else if (dec_en) begin
        borrow_q <= borrow_w;
        if (is_one) begin
          done_q <= 1'b1;
          zero_q <= 1'b1;
          if (!AUTO_RELOAD) begin
            state_q   <= DONE;
            running_q <= 1'b0;
          end
        end
      end else if (reload_evt) begin
        // Reload value is nonzero whenever RUN was entered.
        zero_q <= 1'b0;
      end
    end
  end

  assign bus.digits  = digits_w;
  assign bus.borrow  = borrow_q;
  assign bus.done    = done_q;
  assign bus.running = running_q;
  assign bus.zero    = zero_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed bench for bcd_countdown: one instance stops at zero, one
// auto-reloads. Vector table plus a hand-written asynchronous reset sequence.
module tb_bcd_countdown;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  bcd_countdown_if #(.DIGITS(4)) if0 ();
  bcd_countdown_if #(.DIGITS(4)) if1 ();

  bcd_countdown #(.DIGITS(4), .AUTO_RELOAD(1'b0)) dut0 (
    .clock (clock), .reset (reset), .bus (if0)
  );
  bcd_countdown #(.DIGITS(4), .AUTO_RELOAD(1'b1)) dut1 (
    .clock (clock), .reset (reset), .bus (if1)
  );

  // Clock and reset
  always #5 clock = ~clock;

  typedef struct {
    bit          sel;     // 0 = stop-at-zero DUT, 1 = auto-reload DUT
    logic        load;
    logic [15:0] lv;
    logic        en;
    logic [15:0] e_dig;
    logic [3:0]  e_bor;
    logic        e_done;
    logic        e_run;
    logic        e_zero;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic void add(input bit sel, input logic ld, input logic [15:0] lv,
                              input logic en, input logic [15:0] dig, input logic [3:0] bor,
                              input logic dn, input logic run, input logic zr,
                              input logic [1:0] st);
    vec_t v;
    v.sel = sel; v.load = ld; v.lv = lv; v.en = en; v.e_dig = dig; v.e_bor = bor;
    v.e_done = dn; v.e_run = run; v.e_zero = zr; v.e_state = st;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all status outputs of one DUT against expected values.
  task automatic chk_all(input string tag, input bit sel, input logic [15:0] dig,
                         input logic [3:0] bor, input logic dn, input logic run,
                         input logic zr, input logic [1:0] st);
    if (!sel) begin
      chk({tag, ".digits0"},  if0.digits,  dig);
      chk({tag, ".borrow0"},  {12'd0, if0.borrow}, {12'd0, bor});
      chk({tag, ".flags0"},   {13'd0, if0.done, if0.running, if0.zero}, {13'd0, dn, run, zr});
      chk({tag, ".state0"},   {14'd0, if0.state}, {14'd0, st});
    end else begin
      chk({tag, ".digits1"},  if1.digits,  dig);
      chk({tag, ".borrow1"},  {12'd0, if1.borrow}, {12'd0, bor});
      chk({tag, ".flags1"},   {13'd0, if1.done, if1.running, if1.zero}, {13'd0, dn, run, zr});
      chk({tag, ".state1"},   {14'd0, if1.state}, {14'd0, st});
    end
  endtask

  // Driver: present one vector's inputs, clock once, release inputs.
  task automatic drive(input vec_t v);
    if (!v.sel) begin
      if0.load = v.load; if0.load_value = v.lv; if0.enable = v.en;
    end else begin
      if1.load = v.load; if1.load_value = v.lv; if1.enable = v.en;
    end
    @(posedge clock); #1;
    if0.load = 1'b0; if0.enable = 1'b0; if0.load_value = '0;
    if1.load = 1'b0; if1.enable = 1'b0; if1.load_value = '0;
  endtask

  initial begin
    if0.load = 1'b0; if0.enable = 1'b0; if0.load_value = '0;
    if1.load = 1'b0; if1.enable = 1'b0; if1.load_value = '0;

    // Stop-at-zero: count 0012 down to 0000, then DONE holds.
    add(0, 1, 16'h0012, 1, 16'h0012, 4'b0000, 0, 1, 0, S_RUN);
    add(0, 0, 16'h0000, 1, 16'h0011, 4'b0000, 0, 1, 0, S_RUN);
    add(0, 0, 16'h0000, 1, 16'h0010, 4'b0000, 0, 1, 0, S_RUN);
    add(0, 0, 16'h0000, 1, 16'h0009, 4'b0001, 0, 1, 0, S_RUN);
    for (int v = 8; v >= 1; v--)
      add(0, 0, 16'h0000, 1, 16'(v), 4'b0000, 0, 1, 0, S_RUN);
    add(0, 0, 16'h0000, 1, 16'h0000, 4'b0000, 1, 0, 1, S_DONE);
    add(0, 0, 16'h0000, 1, 16'h0000, 4'b0000, 0, 0, 1, S_DONE);
    add(0, 0, 16'h0000, 1, 16'h0000, 4'b0000, 0, 0, 1, S_DONE);
    // Multi-digit borrow, hold on enable low.
    add(0, 1, 16'h1000, 0, 16'h1000, 4'b0000, 0, 1, 0, S_RUN);
    add(0, 0, 16'h0000, 1, 16'h0999, 4'b0111, 0, 1, 0, S_RUN);
    add(0, 0, 16'h0000, 1, 16'h0998, 4'b0000, 0, 1, 0, S_RUN);
    add(0, 0, 16'h0000, 0, 16'h0998, 4'b0000, 0, 1, 0, S_RUN);
    // Load beats enable; clamping of non-decimal nibbles; loading zero.
    add(0, 1, 16'h0305, 1, 16'h0305, 4'b0000, 0, 1, 0, S_RUN);
    add(0, 0, 16'h0000, 1, 16'h0304, 4'b0000, 0, 1, 0, S_RUN);
    add(0, 1, 16'h00A5, 1, 16'h0095, 4'b0000, 0, 1, 0, S_RUN);
    add(0, 0, 16'h0000, 1, 16'h0094, 4'b0000, 0, 1, 0, S_RUN);
    add(0, 1, 16'hFFFF, 0, 16'h9999, 4'b0000, 0, 1, 0, S_RUN);
    add(0, 1, 16'h0000, 1, 16'h0000, 4'b0000, 0, 0, 1, S_IDLE);
    add(0, 0, 16'h0000, 1, 16'h0000, 4'b0000, 0, 0, 1, S_IDLE);
    // Auto-reload: period of 4 ticks for reload value 3.
    add(1, 1, 16'h0003, 1, 16'h0003, 4'b0000, 0, 1, 0, S_RUN);
    add(1, 0, 16'h0000, 1, 16'h0002, 4'b0000, 0, 1, 0, S_RUN);
    add(1, 0, 16'h0000, 1, 16'h0001, 4'b0000, 0, 1, 0, S_RUN);
    add(1, 0, 16'h0000, 1, 16'h0000, 4'b0000, 1, 1, 1, S_RUN);
    add(1, 0, 16'h0000, 1, 16'h0003, 4'b0000, 0, 1, 0, S_RUN);
    add(1, 0, 16'h0000, 1, 16'h0002, 4'b0000, 0, 1, 0, S_RUN);
    add(1, 0, 16'h0000, 1, 16'h0001, 4'b0000, 0, 1, 0, S_RUN);
    add(1, 0, 16'h0000, 1, 16'h0000, 4'b0000, 1, 1, 1, S_RUN);
    add(1, 0, 16'h0000, 0, 16'h0000, 4'b0000, 0, 1, 1, S_RUN);
    add(1, 0, 16'h0000, 1, 16'h0003, 4'b0000, 0, 1, 0, S_RUN);

    // Reset state of both instances.
    repeat (2) @(posedge clock);
    #1;
    chk_all("reset_low", 0, 16'h0000, 4'b0000, 0, 0, 1, S_IDLE);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_all("reset_rel", 0, 16'h0000, 4'b0000, 0, 0, 1, S_IDLE);
    chk_all("reset_rel", 1, 16'h0000, 4'b0000, 0, 0, 1, S_IDLE);

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      chk_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].e_dig, vecs[i].e_bor,
              vecs[i].e_done, vecs[i].e_run, vecs[i].e_zero, vecs[i].e_state);
    end

    // Asynchronous reset in the middle of a count.
    if0.load = 1'b1; if0.load_value = 16'h0050; if0.enable = 1'b0;
    @(posedge clock); #1;
    if0.load = 1'b0; if0.load_value = '0; if0.enable = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk_all("pre_reset", 0, 16'h0047, 4'b0000, 0, 1, 0, S_RUN);
    #2 reset = 1'b0;
    #1;
    chk_all("async_reset", 0, 16'h0000, 4'b0000, 0, 0, 1, S_IDLE);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      chk_all($sformatf("post_reset%0d", c), 0, 16'h0000, 4'b0000, 0, 0, 1, S_IDLE);
    end
    if0.enable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
